// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver, runtime 5-8 data bits / parity / stop bits, with receive FIFO
module uart_rx_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                              PCLK,
    input  logic                              PRESETn,
    input  logic                              RX,
    input  logic [DIV_W-1:0]                  cfg_div,
    input  logic [1:0]                        cfg_data_bits,
    input  logic                              cfg_parity_en,
    input  logic                              cfg_parity_odd,
    input  logic                              cfg_stop2,
    output logic [DATA_W-1:0]                 rx_data,
    output logic                              rx_perr,
    output logic                              rx_ferr,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    input  logic                              overrun_clr,
    output logic                              busy
);
    localparam int BW = $clog2(DATA_W);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic              prev_q;
    logic [DIV_W-1:0]  div_cnt_q, div_q;
    logic [OW-1:0]     os_cnt_q;
    logic [1:0]        bits_q;
    logic              pen_q, podd_q, stop2_q;
    logic [1:0]        smp_q;
    logic [BW-1:0]     bit_q, bit_d;
    logic              stop_q, stop_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d, ferr_q, ferr_d;
    logic              rx_s, start_edge, tick, mid, bit_end, maj, last_bit, push;
    logic [DATA_W+1:0] word, head;
    logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     count_q;
    logic              overrun_q, pop, full, wr_en;

    assign rx_s       = sync_q[1];
    assign start_edge = (state_q == IDLE) && prev_q && !rx_s;
    assign tick       = div_cnt_q == div_q;
    assign mid        = tick && os_cnt_q == OW'(OVERSAMPLE / 2 + 1);
    assign bit_end    = tick && os_cnt_q == OW'(OVERSAMPLE - 1);
    assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign last_bit   = bit_q == BW'(bits_q) + BW'(4);
    assign word       = {perr_q, ferr_q | ~maj, data_q};

    // Two-flop synchroniser for the asynchronous line plus the falling-edge history flop
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], RX};
            prev_q <= sync_q[1];
        end
    end

    // Oversample tick and per-bit tick counters, realigned to the detected start edge
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div_cnt_q <= '0;
            os_cnt_q  <= '0;
            smp_q     <= '0;
        end else begin
            div_cnt_q <= (start_edge || tick) ? '0 : div_cnt_q + DIV_W'(1);
            os_cnt_q  <= start_edge ? '0 : !tick ? os_cnt_q : bit_end ? '0 : os_cnt_q + OW'(1);
            smp_q     <= (tick && os_cnt_q == OW'(OVERSAMPLE / 2 - 1)) ? {smp_q[1], rx_s} :
                         (tick && os_cnt_q == OW'(OVERSAMPLE / 2))     ? {rx_s, smp_q[0]} : smp_q;
        end
    end

    // Frame configuration is frozen at the start edge so mid-frame changes are ignored
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div_q   <= '0;
            bits_q  <= '0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            stop2_q <= 1'b0;
        end else if (start_edge) begin
            div_q   <= cfg_div;
            bits_q  <= cfg_data_bits;
            pen_q   <= cfg_parity_en;
            podd_q  <= cfg_parity_odd;
            stop2_q <= cfg_stop2;
        end
    end

    // Receiver FSM state and assembled character
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next state: bits decided at the majority tick, bit boundaries at the last tick
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (start_edge) begin
                state_d = START;
                bit_d   = '0;
                stop_d  = 1'b0;
                data_d  = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
            end
            START: state_d = (mid && maj) ? IDLE : bit_end ? DATA : START;
            DATA: begin
                if (mid) data_d[bit_q] = maj;
                if (bit_end) begin
                    bit_d   = bit_q + BW'(1);
                    state_d = !last_bit ? DATA : pen_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (mid) perr_d = maj != (^data_q ^ podd_q);
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (mid) begin
                    ferr_d = ferr_q | ~maj;
                    push   = !(stop2_q && !stop_q);
                    state_d = push ? IDLE : STOP;
                end
                if (bit_end) stop_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop   = rx_valid && rx_ready;
    assign full  = count_q == CW'(FIFO_DEPTH);
    assign wr_en = push && (!full || pop);

    // FIFO storage needs no reset: the head is masked while empty
    always_ff @(posedge PCLK) begin
        if (wr_en) mem_q[wr_q] <= word;
    end

    // FIFO pointers, occupancy and sticky overrun (set wins over clear)
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_q      <= wr_q + PW'(wr_en);
            rd_q      <= rd_q + PW'(pop);
            count_q   <= count_q + CW'(wr_en) - CW'(pop);
            overrun_q <= (push && full && !pop) ? 1'b1 : overrun_clr ? 1'b0 : overrun_q;
        end
    end

    assign head       = mem_q[rd_q];
    assign rx_valid   = count_q != '0;
    assign rx_data    = rx_valid ? head[DATA_W-1:0] : '0;
    assign rx_perr    = rx_valid & head[DATA_W+1];
    assign rx_ferr    = rx_valid & head[DATA_W];
    assign fifo_count = count_q;
    assign overrun    = overrun_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames checked against a queue-based character model
module tb_uart_rx_param;
    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       RX = 1'b1;
    logic [15:0] cfg_div = '0;
    logic [1:0] cfg_data_bits = 2'd3;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic [7:0] rx_data;
    logic       rx_perr, rx_ferr, rx_valid, rx_ready;
    logic [3:0] fifo_count;
    logic       overrun;
    logic       overrun_clr = 1'b0;
    logic       busy;
    logic       man_ready = 1'b0;
    logic       rnd_ready = 1'b1;
    logic       rand_mode = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] exp_q[$];
    logic       exp_ovr = 1'b0;

    assign rx_ready = rand_mode ? rnd_ready : man_ready;

    uart_rx_param dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .RX(RX), .cfg_div(cfg_div),
        .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .fifo_count(fifo_count), .overrun(overrun),
        .overrun_clr(overrun_clr), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        #1;
        rnd_ready = $urandom_range(0, 3) != 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    // Expected {perr, ferr, data} of a frame, from what was put on the wire
    function automatic logic [9:0] mdl(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                                       input bit pbit, input bit stop2, input bit s1, input bit s2);
        logic [7:0] m;
        bit pe, fe;
        m  = d & 8'((1 << nb) - 1);
        pe = pen && (pbit != ((($countones(m) % 2) == 1) ^ podd));
        fe = !s1 || (stop2 && !s2);
        return {pe, fe, m};
    endfunction

    task automatic scramble();
        cfg_div        = 16'($urandom);
        cfg_data_bits  = 2'($urandom);
        cfg_parity_en  = 1'($urandom);
        cfg_parity_odd = 1'($urandom);
        cfg_stop2      = 1'($urandom);
    endtask

    task automatic send(input logic [7:0] d, input int nb, input bit pen, input bit podd, input bit pbit,
                        input bit stop2, input bit s1, input bit s2, input int div, input int abort,
                        input bit glitch);
        bit fb[12];
        int n;
        int p;
        n = 0;
        p = (div + 1) * 16;
        fb[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin fb[n] = d[i]; n++; end
        if (pen) begin fb[n] = pbit; n++; end
        fb[n] = s1; n++;
        if (stop2) begin fb[n] = s2; n++; end
        cfg_div        = 16'(div);
        cfg_data_bits  = 2'(nb - 5);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = stop2;
        if (abort < 0) begin
            if (exp_q.size() >= 8) exp_ovr = 1'b1;
            else exp_q.push_back(mdl(d, nb, pen, podd, pbit, stop2, s1, s2));
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort) return;
            for (int c = 0; c < p; c++) begin
                RX = (glitch && i == 3 && c >= 9 * (div + 1) && c < 10 * (div + 1)) ? !fb[i] : fb[i];
                cyc();
            end
            if (i == 0) scramble();
        end
        RX = 1'b1;
    endtask

    task automatic send8(input logic [7:0] d);
        send(d, 8, 0, 0, 0, 0, 1, 1, 0, -1, 0);
        repeat (4) cyc();
    endtask

    task automatic pop_one();
        man_ready = 1'b1;
        cyc();
        man_ready = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) cyc();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_perr"}, rx_perr, 0);
        chk({tag, "_ferr"}, rx_ferr, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Every pop must deliver the oldest expected character
    always @(negedge PCLK) begin
        if (PRESETn) begin
            chk("valid_vs_count", 32'(rx_valid), 32'(fifo_count != 0));
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no character", {rx_perr, rx_ferr, rx_data});
                end else chk("pop_word", {rx_perr, rx_ferr, rx_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) cyc();
        chk_reset_vals("reset");
        PRESETn = 1'b1;
        repeat (3) cyc();

        send8(8'hA5);
        chk("a5_valid", rx_valid, 1);
        chk("a5_data", rx_data, 32'hA5);
        chk("a5_perr", rx_perr, 0);
        chk("a5_ferr", rx_ferr, 0);
        chk("a5_count", fifo_count, 1);
        pop_one();
        chk("a5_popped", rx_valid, 0);

        send(8'h35, 7, 1, 0, 1, 0, 1, 1, 3, -1, 0);
        repeat (4) cyc();
        chk("7e1_bad_data", rx_data, 32'h35);
        chk("7e1_bad_perr", rx_perr, 1);
        chk("7e1_bad_ferr", rx_ferr, 0);
        pop_one();
        send(8'h35, 7, 1, 0, 0, 0, 1, 1, 3, -1, 0);
        repeat (4) cyc();
        chk("7e1_ok_perr", rx_perr, 0);
        pop_one();
        send(8'h1F, 5, 1, 1, 0, 1, 1, 1, 3, -1, 0);
        repeat (4) cyc();
        chk("5o2_data", rx_data, 32'h1F);
        chk("5o2_perr", rx_perr, 0);
        pop_one();

        send(8'hC3, 8, 0, 0, 0, 1, 1, 0, 0, -1, 0);
        repeat (4) cyc();
        chk("8n2_ferr", rx_ferr, 1);
        chk("8n2_data", rx_data, 32'hC3);
        pop_one();
        send(8'h77, 8, 0, 0, 0, 0, 0, 1, 0, -1, 0);
        repeat (4) cyc();
        chk("8n1_ferr", rx_ferr, 1);
        pop_one();
        repeat (16) cyc();
        send8(8'h3C);
        chk("clean_data", rx_data, 32'h3C);
        chk("clean_ferr", rx_ferr, 0);
        pop_one();

        cfg_div = 16'd1;
        RX = 1'b0;
        repeat (8) cyc();
        RX = 1'b1;
        chk("glitch_busy", busy, 1);
        repeat (64) cyc();
        chk("glitch_idle", busy, 0);
        chk("glitch_count", fifo_count, 0);
        send(8'hF0, 8, 0, 0, 0, 0, 1, 1, 0, -1, 1);
        repeat (4) cyc();
        chk("centre_glitch", rx_data, 32'hF0);
        pop_one();

        send(8'h55, 7, 0, 0, 0, 0, 1, 1, 1, -1, 0);
        repeat (4) cyc();
        chk("latched_cfg", rx_data, 32'h55);
        pop_one();

        for (int i = 1; i <= 9; i++) send8(8'(i));
        chk("ovr_count", fifo_count, 8);
        chk("ovr_flag", overrun, 32'(exp_ovr));
        chk("ovr_lit", overrun, 1);
        chk("ovr_head", rx_data, 32'h01);
        man_ready = 1'b1;
        wait_drain();
        man_ready = 1'b0;
        chk("ovr_drained", fifo_count, 0);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        exp_ovr = 1'b0;
        chk("ovr_clr", overrun, 0);

        send8(8'h11);
        send8(8'h22);
        send8(8'h33);
        send(8'h99, 8, 0, 0, 0, 0, 1, 1, 0, 4, 0);
        chk("pre_rst_count", fifo_count, 3);
        chk("pre_rst_busy", busy, 1);
        PRESETn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        exp_q.delete();
        RX = 1'b1;
        repeat (3) cyc();
        PRESETn = 1'b1;
        repeat (3) cyc();
        send8(8'h5A);
        chk("post_rst_data", rx_data, 32'h5A);
        chk("post_rst_count", fifo_count, 1);
        pop_one();

        rand_mode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int nb, dv;
            bit pen, podd, pbit, st2, s1, s2, gl;
            logic [7:0] d;
            d    = 8'($urandom);
            nb   = $urandom_range(5, 8);
            pen  = 1'($urandom);
            podd = 1'($urandom);
            pbit = 1'($urandom);
            st2  = 1'($urandom);
            s1   = $urandom_range(0, 7) != 0;
            s2   = $urandom_range(0, 7) != 0;
            dv   = $urandom_range(0, 2);
            gl   = 1'($urandom);
            send(d, nb, pen, podd, pbit, st2, s1, s2, dv, -1, gl);
            repeat (((st2 ? s2 : s1) ? 0 : 4) + $urandom_range(0, 8)) cyc();
        end
        rand_mode = 1'b0;
        man_ready = 1'b1;
        wait_drain();
        man_ready = 1'b0;
        chk("final_count", fifo_count, 0);
        chk("final_ovr", overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
